mult_arbiter: RTL



---
 rtl/mult_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one pipelined signed 32x32 multiplier.
// Define MULT_ARB_STATS_EN to add the stat_grants/stat_conflicts counters.
module mult_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [32*NREQ-1:0] req_a,
   input  logic [32*NREQ-1:0] req_b,
   output logic [NREQ-1:0]    rsp_valid,
   input  logic [NREQ-1:0]    rsp_ready,
   output logic [64*NREQ-1:0] rsp_data,
   output logic [31:0]        mul_a,
   output logic [31:0]        mul_b,
   input  logic [63:0]        mul_p
`ifdef MULT_ARB_STATS_EN
   ,
   output logic [31:0]        stat_grants,
   output logic [31:0]        stat_conflicts
`endif
);

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]         busy_q, busy_d;
   logic [NREQ-1:0]         rv_q, rv_d;
   logic [NREQ-1:0][63:0]   rd_q;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [31:0]             mul_a_q, mul_b_q;
   logic [LAT:0]            tv_q;
   logic [LAT:0][IW-1:0]    ti_q;
   logic [NREQ-1:0]         elig;
   logic [NREQ-1:0]         grant;
   logic [NREQ-1:0]         hs;
   logic [IW-1:0]           gidx;
   logic                    gnt_any;
   logic [31:0]             a_sel, b_sel;
   int                      j;

   assign elig      = req_valid & ~busy_q;
   assign hs        = rv_q & rsp_ready;
   assign req_ready = grant;
   assign rsp_valid = rv_q;
   assign rsp_data  = rd_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

   // Round-robin pick: first eligible index at or after ptr wins.
   always_comb begin
      grant   = '0;
      gidx    = '0;
      gnt_any = 1'b0;
      a_sel   = '0;
      b_sel   = '0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!gnt_any && elig[j] && !reset) begin
            gnt_any  = 1'b1;
            grant[j] = 1'b1;
            gidx     = IW'(j);
            a_sel    = req_a[32*j +: 32];
            b_sel    = req_b[32*j +: 32];
         end
      end
   end

   // Next-state for pointer, busy flags and response slots.
   always_comb begin
      ptr_d  = ptr_q;
      busy_d = (busy_q & ~hs) | grant;
      rv_d   = rv_q & ~hs;
      if (gnt_any)
         ptr_d = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
      if (tv_q[LAT])
         rv_d[ti_q[LAT]] = 1'b1;
   end

   // Tag stage 0 lines up with mul_a/mul_b, stage LAT with mul_p.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q  <= '0;
         rv_q    <= '0;
         rd_q    <= '0;
         ptr_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         tv_q    <= '0;
         ti_q    <= '0;
      end else begin
         busy_q <= busy_d;
         rv_q   <= rv_d;
         ptr_q  <= ptr_d;
         tv_q   <= {tv_q[LAT-1:0], gnt_any};
         ti_q   <= {ti_q[LAT-1:0], gidx};
         if (gnt_any) begin
            mul_a_q <= a_sel;
            mul_b_q <= b_sel;
         end
         if (tv_q[LAT])
            rd_q[ti_q[LAT]] <= mul_p;
      end
   end

`ifdef MULT_ARB_STATS_EN
   logic [31:0] sg_q, sc_q;

   assign stat_grants    = sg_q;
   assign stat_conflicts = sc_q;

   // Free-running grant and contention counters, wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         sg_q <= '0;
         sc_q <= '0;
      end else begin
         if (gnt_any)
            sg_q <= sg_q + 32'd1;
         if ($countones(elig) > 1)
            sc_q <= sc_q + 32'd1;
      end
   end
`endif

endmodule
